// File: rtl/trap_csr_unit_if.sv
// Bus bundle for trap_csr_unit: enable, trap/return requests, CSR access
// and the fetch-redirect / pipeline-control outputs.
interface trap_csr_unit_if;
    logic        EN;
    logic        TRAP_VALID;
    logic [31:0] TRAP_TVAL;
    logic        ECALL_i;
    logic        EBREAK_i;
    logic [31:0] TRAP_PC;
    logic        MRET_i;
    logic [11:0] CSR_ADDR;
    logic [31:0] CSR_WDATA;
    logic        CSR_WE;
    logic [31:0] CSR_RDATA;
    logic        CSR_ERR;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        FLUSH;
    logic        STALL;

    modport master (
        output EN, TRAP_VALID, TRAP_TVAL, ECALL_i, EBREAK_i, TRAP_PC, MRET_i,
               CSR_ADDR, CSR_WDATA, CSR_WE,
        input  CSR_RDATA, CSR_ERR, REDIRECT_VALID, REDIRECT_PC, FLUSH, STALL
    );

    modport slave (
        input  EN, TRAP_VALID, TRAP_TVAL, ECALL_i, EBREAK_i, TRAP_PC, MRET_i,
               CSR_ADDR, CSR_WDATA, CSR_WE,
        output CSR_RDATA, CSR_ERR, REDIRECT_VALID, REDIRECT_PC, FLUSH, STALL
    );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: holds the M-mode CSRs, takes illegal/ecall/
// ebreak traps and mret returns, and issues a one-cycle fetch redirect.
module trap_csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic           CLK,
    input  logic           RSTn,
    trap_csr_unit_if.slave bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;

    typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;

    state_t      state_q, state_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, mcycle_q, mcycle_d;
    logic        trap_req;
    logic        active;

    assign trap_req = bus.TRAP_VALID | bus.ECALL_i | bus.EBREAK_i;

    // Next-state: request acceptance, trap entry/return and CSR writes.
    // A trap takes the whole cycle: a concurrent write or mret is dropped.
    always_comb begin
        state_d    = state_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = bus.EN ? mcycle_q + 32'd1 : mcycle_q;
        if (bus.EN) begin
            case (state_q)
                IDLE: begin
                    if (trap_req) begin
                        mepc_d  = bus.TRAP_PC & ~32'h3;
                        mpie_d  = mie_q;
                        mie_d   = 1'b0;
                        state_d = ENTER;
                        if (bus.TRAP_VALID) begin
                            mcause_d = 32'd2;
                            mtval_d  = bus.TRAP_TVAL;
                        end else if (bus.EBREAK_i) begin
                            mcause_d = 32'd3;
                            mtval_d  = bus.TRAP_PC;
                        end else begin
                            mcause_d = 32'd11;
                            mtval_d  = '0;
                        end
                    end else begin
                        if (bus.CSR_WE) begin
                            case (bus.CSR_ADDR)
                                A_MSTATUS: begin
                                    mie_d  = bus.CSR_WDATA[3];
                                    mpie_d = bus.CSR_WDATA[7];
                                end
                                A_MTVEC:    mtvec_d    = bus.CSR_WDATA & ~32'h3;
                                A_MSCRATCH: mscratch_d = bus.CSR_WDATA;
                                A_MEPC:     mepc_d     = bus.CSR_WDATA & ~32'h3;
                                A_MCAUSE:   mcause_d   = bus.CSR_WDATA;
                                A_MTVAL:    mtval_d    = bus.CSR_WDATA;
                                A_MCYCLE:   mcycle_d   = bus.CSR_WDATA;
                                default:    ;
                            endcase
                        end
                        if (bus.MRET_i) begin
                            mie_d   = mpie_q;
                            mpie_d  = 1'b1;
                            state_d = RETURN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and CSR registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
        end
    end

    // Combinational CSR read port; unimplemented addresses read 0 and flag error.
    always_comb begin
        bus.CSR_RDATA = '0;
        bus.CSR_ERR   = 1'b0;
        case (bus.CSR_ADDR)
            A_MSTATUS:  bus.CSR_RDATA = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
            A_MTVEC:    bus.CSR_RDATA = mtvec_q;
            A_MSCRATCH: bus.CSR_RDATA = mscratch_q;
            A_MEPC:     bus.CSR_RDATA = mepc_q;
            A_MCAUSE:   bus.CSR_RDATA = mcause_q;
            A_MTVAL:    bus.CSR_RDATA = mtval_q;
            A_MCYCLE:   bus.CSR_RDATA = mcycle_q;
            default:    bus.CSR_ERR   = 1'b1;
        endcase
    end

    // Redirect/pipeline outputs; gated by RSTn so reset kills a pending redirect at once.
    always_comb begin
        active             = RSTn && (state_q != IDLE);
        bus.REDIRECT_VALID = active;
        bus.FLUSH          = active;
        bus.STALL          = active;
        bus.REDIRECT_PC    = '0;
        if (active) begin
            bus.REDIRECT_PC = (state_q == ENTER) ? mtvec_q : mepc_q;
        end
    end
endmodule

// File: tb/tb_trap_csr_unit.sv
// Self-checking bench for trap_csr_unit: directed scenarios plus a random
// run checked against a cycle-level reference model of the CSR/trap rules.
module tb_trap_csr_unit;
    logic CLK;
    logic RSTn;
    trap_csr_unit_if bus ();

    trap_csr_unit #(.MTVEC_RESET(32'h0000_0100)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: architectural CSR values and a pending redirect.
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle;
    logic        m_pend;
    logic [31:0] m_ppc;

    function automatic logic [32:0] mread(input logic [11:0] a);
        case (a)
            12'h300: mread = {1'b0, 24'd0, m_mpie, 3'd0, m_mie, 3'd0};
            12'h305: mread = {1'b0, m_mtvec};
            12'h340: mread = {1'b0, m_mscratch};
            12'h341: mread = {1'b0, m_mepc};
            12'h342: mread = {1'b0, m_mcause};
            12'h343: mread = {1'b0, m_mtval};
            12'hB00: mread = {1'b0, m_mcycle};
            default: mread = {1'b1, 32'd0};
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] nc;
        if (!RSTn) begin
            m_mie = 0; m_mpie = 0; m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0;
            m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_pend = 0; m_ppc = 0;
        end else if (bus.EN) begin
            nc = m_mcycle + 1;
            if (m_pend) begin
                m_pend = 0;
            end else if (bus.TRAP_VALID || bus.EBREAK_i || bus.ECALL_i) begin
                m_mepc = {bus.TRAP_PC[31:2], 2'b00};
                m_mpie = m_mie;
                m_mie  = 0;
                if (bus.TRAP_VALID)    begin m_mcause = 2;  m_mtval = bus.TRAP_TVAL; end
                else if (bus.EBREAK_i) begin m_mcause = 3;  m_mtval = bus.TRAP_PC;   end
                else                   begin m_mcause = 11; m_mtval = 0;             end
                m_pend = 1; m_ppc = m_mtvec;
            end else begin
                if (bus.CSR_WE) begin
                    case (bus.CSR_ADDR)
                        12'h300: begin m_mie = bus.CSR_WDATA[3]; m_mpie = bus.CSR_WDATA[7]; end
                        12'h305: m_mtvec    = {bus.CSR_WDATA[31:2], 2'b00};
                        12'h340: m_mscratch = bus.CSR_WDATA;
                        12'h341: m_mepc     = {bus.CSR_WDATA[31:2], 2'b00};
                        12'h342: m_mcause   = bus.CSR_WDATA;
                        12'h343: m_mtval    = bus.CSR_WDATA;
                        12'hB00: nc         = bus.CSR_WDATA;
                        default: ;
                    endcase
                end
                if (bus.MRET_i) begin
                    m_mie = m_mpie; m_mpie = 1; m_pend = 1; m_ppc = m_mepc;
                end
            end
            m_mcycle = nc;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.EN = 1; bus.TRAP_VALID = 0; bus.TRAP_TVAL = 0; bus.ECALL_i = 0; bus.EBREAK_i = 0;
        bus.TRAP_PC = 0; bus.MRET_i = 0; bus.CSR_WE = 0; bus.CSR_WDATA = 0; bus.CSR_ADDR = 12'h300;
    endtask

    task automatic peek(input logic [11:0] a, output logic [31:0] d, output logic e);
        bus.CSR_ADDR = a;
        #1;
        d = bus.CSR_RDATA;
        e = bus.CSR_ERR;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        bus.CSR_ADDR = a; bus.CSR_WDATA = d; bus.CSR_WE = 1;
        tick();
        bus.CSR_WE = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        idle_inputs();
        RSTn = 0;
        tick(); tick();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0 || bus.FLUSH !== 1'b0 || bus.STALL !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got v=%b f=%b s=%b want 0", bus.REDIRECT_VALID, bus.FLUSH, bus.STALL); end
        n_checks++; if (bus.REDIRECT_PC !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h want 0", bus.REDIRECT_PC); end
        peek(12'h305, d, e);
        n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL reset_mtvec: got %h want 100", d); end
        peek(12'hB00, d, e);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mcycle: got %h want 0", d); end
        peek(12'h300, d, e);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mstatus: got %h want 0", d); end
        RSTn = 1;
    endtask

    task automatic test_illegal();
        logic [31:0] d; logic e;
        idle_inputs();
        csr_write(12'h300, 32'h8);
        peek(12'h300, d, e);
        n_checks++; if (d !== 32'h8) begin n_fail++; $display("FAIL mie_set: got %h want 8", d); end
        bus.TRAP_VALID = 1; bus.TRAP_PC = 32'h40; bus.TRAP_TVAL = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b1 || bus.REDIRECT_PC !== 32'h100 || bus.FLUSH !== 1'b1 || bus.STALL !== 1'b1) begin
            n_fail++; $display("FAIL ill_redirect: got v=%b pc=%h f=%b s=%b want 1/100/1/1", bus.REDIRECT_VALID, bus.REDIRECT_PC, bus.FLUSH, bus.STALL); end
        peek(12'h341, d, e);
        n_checks++; if (d !== 32'h40) begin n_fail++; $display("FAIL ill_mepc: got %h want 40", d); end
        peek(12'h342, d, e);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL ill_mcause: got %h want 2", d); end
        peek(12'h343, d, e);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ill_mtval: got %h want ffffffff", d); end
        peek(12'h300, d, e);
        n_checks++; if (d !== 32'h80) begin n_fail++; $display("FAIL ill_mstatus: got %h want 80", d); end
        tick();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0 || bus.REDIRECT_PC !== 32'h0) begin
            n_fail++; $display("FAIL ill_oneshot: got v=%b pc=%h want 0/0", bus.REDIRECT_VALID, bus.REDIRECT_PC); end
    endtask

    task automatic test_priority();
        logic [31:0] d; logic e;
        idle_inputs();
        bus.TRAP_VALID = 1; bus.ECALL_i = 1; bus.MRET_i = 1; bus.TRAP_PC = 32'h1237; bus.TRAP_TVAL = 32'hABCD;
        tick();
        idle_inputs();
        peek(12'h342, d, e);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL prio_mcause: got %h want 2", d); end
        n_checks++; if (bus.REDIRECT_VALID !== 1'b1 || bus.REDIRECT_PC !== 32'h100) begin
            n_fail++; $display("FAIL prio_enter: got v=%b pc=%h want 1/100", bus.REDIRECT_VALID, bus.REDIRECT_PC); end
        tick();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0) begin n_fail++; $display("FAIL prio_no_return: got %b want 0", bus.REDIRECT_VALID); end
        tick();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0) begin n_fail++; $display("FAIL prio_single: got %b want 0", bus.REDIRECT_VALID); end
        // EBREAK outranks ECALL
        bus.EBREAK_i = 1; bus.ECALL_i = 1; bus.TRAP_PC = 32'h2000_0010;
        tick();
        idle_inputs();
        peek(12'h342, d, e);
        n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL ebreak_mcause: got %h want 3", d); end
        peek(12'h343, d, e);
        n_checks++; if (d !== 32'h2000_0010) begin n_fail++; $display("FAIL ebreak_mtval: got %h want 20000010", d); end
        tick();
        bus.ECALL_i = 1; bus.TRAP_TVAL = 32'h5555;
        tick();
        idle_inputs();
        peek(12'h342, d, e);
        n_checks++; if (d !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause: got %h want b", d); end
        peek(12'h343, d, e);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ecall_mtval: got %h want 0", d); end
        tick();
    endtask

    task automatic test_mret();
        logic [31:0] d; logic e;
        idle_inputs();
        csr_write(12'h300, 32'h80);
        csr_write(12'h341, 32'h87);
        peek(12'h341, d, e);
        n_checks++; if (d !== 32'h84) begin n_fail++; $display("FAIL mepc_align: got %h want 84", d); end
        bus.MRET_i = 1;
        tick();
        idle_inputs();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b1 || bus.REDIRECT_PC !== 32'h84 || bus.FLUSH !== 1'b1 || bus.STALL !== 1'b1) begin
            n_fail++; $display("FAIL mret_redirect: got v=%b pc=%h f=%b s=%b want 1/84/1/1", bus.REDIRECT_VALID, bus.REDIRECT_PC, bus.FLUSH, bus.STALL); end
        peek(12'h300, d, e);
        n_checks++; if (d !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus: got %h want 88", d); end
        // requests during RETURN are ignored
        bus.TRAP_VALID = 1; bus.CSR_WE = 1; bus.CSR_ADDR = 12'h340; bus.CSR_WDATA = 32'hDEAD;
        tick();
        idle_inputs();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0) begin n_fail++; $display("FAIL return_ignore: got %b want 0", bus.REDIRECT_VALID); end
        peek(12'h340, d, e);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL return_nowrite: got %h want 0", d); end
    endtask

    task automatic test_csr();
        logic [31:0] d; logic e;
        idle_inputs();
        csr_write(12'h305, 32'h0000_0203);
        peek(12'h305, d, e);
        n_checks++; if (d !== 32'h200 || e !== 1'b0) begin n_fail++; $display("FAIL mtvec_align: got %h err=%b want 200/0", d, e); end
        csr_write(12'h7C0, 32'h1234_5678);
        peek(12'h7C0, d, e);
        n_checks++; if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL unimpl: got %h err=%b want 0/1", d, e); end
        // trap wins over a simultaneous write, which is dropped
        bus.ECALL_i = 1; bus.TRAP_PC = 32'h300; bus.CSR_WE = 1; bus.CSR_ADDR = 12'h340; bus.CSR_WDATA = 32'hBEEF;
        tick();
        idle_inputs();
        n_checks++; if (bus.REDIRECT_PC !== 32'h200) begin n_fail++; $display("FAIL trap_new_mtvec: got %h want 200", bus.REDIRECT_PC); end
        peek(12'h340, d, e);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL trap_drops_write: got %h want 0", d); end
        tick();
    endtask

    task automatic test_counter();
        logic [31:0] d; logic e;
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFFF; exp_seq[1] = 32'h0; exp_seq[2] = 32'h1;
        idle_inputs();
        csr_write(12'hB00, 32'hFFFF_FFFE);
        peek(12'hB00, d, e);
        n_checks++; if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mcycle_wr: got %h want fffffffe", d); end
        for (int i = 0; i < 3; i++) begin
            tick();
            peek(12'hB00, d, e);
            n_checks++; if (d !== exp_seq[i]) begin n_fail++; $display("FAIL mcycle_inc%0d: got %h want %h", i, d, exp_seq[i]); end
        end
        bus.EN = 0;
        tick(); tick();
        peek(12'hB00, d, e);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL mcycle_hold: got %h want 1", d); end
        // EN=0 blocks acceptance
        bus.EBREAK_i = 1;
        tick();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0) begin n_fail++; $display("FAIL en_block: got %b want 0", bus.REDIRECT_VALID); end
        idle_inputs();
    endtask

    task automatic test_en_hold();
        idle_inputs();
        bus.TRAP_VALID = 1; bus.TRAP_PC = 32'h80;
        tick();
        idle_inputs();
        bus.EN = 0;
        tick(); tick();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b1 || bus.REDIRECT_PC !== 32'h200) begin
            n_fail++; $display("FAIL en_hold: got v=%b pc=%h want 1/200", bus.REDIRECT_VALID, bus.REDIRECT_PC); end
        bus.EN = 1;
        tick();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0) begin n_fail++; $display("FAIL en_release: got %b want 0", bus.REDIRECT_VALID); end
    endtask

    task automatic test_reset_mid_enter();
        logic [31:0] d; logic e;
        idle_inputs();
        bus.ECALL_i = 1; bus.TRAP_PC = 32'h44;
        tick();
        idle_inputs();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b1) begin n_fail++; $display("FAIL rst_pre_enter: got %b want 1", bus.REDIRECT_VALID); end
        RSTn = 0;
        #1;
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0 || bus.FLUSH !== 1'b0 || bus.REDIRECT_PC !== 32'h0) begin
            n_fail++; $display("FAIL rst_same_cycle: got v=%b f=%b pc=%h want 0/0/0", bus.REDIRECT_VALID, bus.FLUSH, bus.REDIRECT_PC); end
        tick();
        RSTn = 1;
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_after: got %b want 0", bus.REDIRECT_VALID); end
        peek(12'h305, d, e);
        n_checks++; if (d !== 32'h100) begin n_fail++; $display("FAIL rst_mtvec: got %h want 100", d); end
        peek(12'h342, d, e);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mcause: got %h want 0", d); end
        tick();
        n_checks++; if (bus.REDIRECT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_no_redirect: got %b want 0", bus.REDIRECT_VALID); end
    endtask

    task automatic test_random();
        logic [11:0] addrs [10];
        logic [31:0] d; logic e;
        logic [32:0] exp;
        logic [11:0] a;
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h340; addrs[3] = 12'h341; addrs[4] = 12'h342;
        addrs[5] = 12'h343; addrs[6] = 12'hB00; addrs[7] = 12'h7C0; addrs[8] = 12'h301; addrs[9] = 12'hB80;
        for (int unsigned c = 0; c < 400; c++) begin
            idle_inputs();
            n_checks++; if (bus.REDIRECT_VALID !== (m_pend && RSTn)) begin
                n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.REDIRECT_VALID, m_pend && RSTn); end
            n_checks++; if (bus.REDIRECT_PC !== ((m_pend && RSTn) ? m_ppc : 32'h0)) begin
                n_fail++; $display("FAIL rnd_pc@%0d: got %h want %h", c, bus.REDIRECT_PC, (m_pend && RSTn) ? m_ppc : 32'h0); end
            n_checks++; if (bus.FLUSH !== (m_pend && RSTn) || bus.STALL !== (m_pend && RSTn)) begin
                n_fail++; $display("FAIL rnd_fs@%0d: got f=%b s=%b want %b", c, bus.FLUSH, bus.STALL, m_pend && RSTn); end
            a = addrs[$urandom_range(9)];
            peek(a, d, e);
            exp = mread(a);
            n_checks++; if (d !== exp[31:0] || e !== exp[32]) begin
                n_fail++; $display("FAIL rnd_csr@%0d addr=%h: got %h err=%b want %h err=%b", c, a, d, e, exp[31:0], exp[32]); end
            RSTn          = ($urandom_range(79) != 0);
            bus.EN        = ($urandom_range(7) != 0);
            bus.TRAP_VALID = ($urandom_range(9) == 0);
            bus.ECALL_i   = ($urandom_range(9) == 0);
            bus.EBREAK_i  = ($urandom_range(9) == 0);
            bus.MRET_i    = ($urandom_range(6) == 0);
            bus.TRAP_PC   = $urandom;
            bus.TRAP_TVAL = $urandom;
            bus.CSR_WE    = !bus.MRET_i && ($urandom_range(2) == 0);
            bus.CSR_ADDR  = addrs[$urandom_range(9)];
            bus.CSR_WDATA = $urandom;
            tick();
        end
        RSTn = 1;
        idle_inputs();
    endtask

    initial begin
        RSTn = 0;
        idle_inputs();
        test_reset();
        test_illegal();
        test_priority();
        test_mret();
        test_csr();
        test_counter();
        test_en_hold();
        test_reset_mid_enter();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_csr_unit.md
TRAP_CSR_UNIT -- requirements
Module: trap_csr_unit

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0100, giving the mtvec reset value.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port RSTn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port EN  input  1  global enable; 0 freezes the FSM and mcycle and blocks request acceptance.
REQ-005 SHALL have port TRAP_VALID  input  1  illegal-instruction trap request (DECODE_TRAP from the trap stage).
REQ-006 SHALL have port TRAP_TVAL  input  32  faulting instruction word (xreg_value from the trap stage).
REQ-007 SHALL have port ECALL_i / EBREAK_i  input  1 each  environment-call and breakpoint requests from decode.
REQ-008 SHALL have port TRAP_PC  input  32  PC of the instruction raising the request.
REQ-009 SHALL have port MRET_i  input  1  return request (EXECUTE_MRET).
REQ-010 SHALL have ports CSR_ADDR  input  12, CSR_WDATA  input  32, CSR_WE  input  1  software CSR access.
REQ-011 SHALL have port CSR_RDATA  output  32  combinational read data for CSR_ADDR.
REQ-012 SHALL have port CSR_ERR  output  1  combinational; 1 when CSR_ADDR is unimplemented.
REQ-013 SHALL have ports REDIRECT_VALID  output  1, REDIRECT_PC  output  32  fetch redirect.
REQ-014 SHALL have ports FLUSH  output  1 and STALL  output  1  pipeline control.

Function
REQ-015 SHALL implement mstatus 0x300 (only MIE bit3 and MPIE bit7 stored; other bits read 0), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, and mcycle 0xB00.
REQ-016 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write (direct mode only).
REQ-017 SHALL read unimplemented addresses as 0, ignore writes to them, and assert CSR_ERR.
REQ-018 SHALL implement FSM states IDLE, ENTER, and RETURN; requests are accepted only in IDLE with EN=1.
REQ-019 SHALL, on a request in IDLE at edge N, load mepc<=TRAP_PC&~3, MPIE<=MIE, MIE<=0, and go to ENTER.
REQ-020 SHALL select the source as illegal (mcause=2, mtval=TRAP_TVAL) > EBREAK (mcause=3, mtval=TRAP_PC) > ECALL (mcause=11, mtval=0).
REQ-021 SHALL, in ENTER (cycle N+1), assert REDIRECT_VALID=1, REDIRECT_PC=mtvec, FLUSH=1, STALL=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL, on MRET_i in IDLE, set MIE<=MPIE and MPIE<=1 and go to RETURN.
REQ-023 SHALL, in RETURN, assert REDIRECT_VALID=1, REDIRECT_PC=mepc, FLUSH=1, STALL=1 for one cycle, then return to IDLE.
REQ-024 SHALL give any trap priority over a simultaneous MRET_i; the MRET is dropped.
REQ-025 SHALL ignore all trap, MRET, and CSR_WE inputs in ENTER or RETURN; no queuing.
REQ-026 SHALL apply a CSR_WE write in IDLE at the edge; a trap accepted in the same cycle wins and the write is dropped entirely.
REQ-027 SHALL hold REDIRECT_VALID, FLUSH, and STALL at 0 in IDLE.
REQ-028 SHALL make REDIRECT_PC 0 when REDIRECT_VALID=0.
REQ-029 SHALL increment mcycle by 1 each cycle EN=1, wrapping 32'hFFFF_FFFF->0; a CSR write to mcycle that cycle wins over the increment.
REQ-030 SHALL, with EN=0 in ENTER or RETURN, hold the state and outputs until EN returns to 1.

Reset
REQ-031 SHALL, on RSTn=0 at an edge, set state=IDLE, mtvec=MTVEC_RESET, and all other CSRs including mcycle=0.
REQ-032 SHALL hold REDIRECT_VALID, FLUSH, and STALL at 0 during reset.
REQ-033 SHALL abort an in-progress ENTER or RETURN on reset, with no redirect issued.

Verification
REQ-034 SHALL cover illegal trap: TRAP_VALID=1, TRAP_PC=0x0000_0040, TRAP_TVAL=0xFFFF_FFFF, MIE=1 -> next cycle REDIRECT_VALID=1, REDIRECT_PC=0x100, mepc=0x40, mcause=2, mtval=0xFFFF_FFFF, MIE=0, MPIE=1.
REQ-035 SHALL cover priority: TRAP_VALID=ECALL_i=MRET_i=1 -> mcause=2, no RETURN state, one redirect pulse only.
REQ-036 SHALL cover MRET: write mepc=0x0000_0087, then MRET_i=1 -> mepc reads 0x84, redirect to 0x84, MIE<=previous MPIE, MPIE=1.
REQ-037 SHALL cover CSR access: write mtvec=0x0000_0203 -> reads 0x200; read 0x7C0 -> CSR_RDATA=0, CSR_ERR=1.
REQ-038 SHALL cover counter: write mcycle=0xFFFF_FFFE, EN=1 for 3 cycles -> reads 0xFFFF_FFFF, 0x0, 0x1; with EN=0 the value holds.
REQ-039 SHALL cover reset mid-ENTER: RSTn=0 during ENTER -> REDIRECT_VALID=0 the same cycle onward, mtvec=0x100, mcause=0.
